// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one simple-dual-port SRAM among several requesters.
// Reads and writes are arbitrated independently, so one read and one write can
// issue in the same cycle. Read data returns one cycle after the read grant and
// is tagged to its requester through rvalid.
module sram_arbiter #(
    parameter int NUM_CLIENTS = 2,
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_CLIENTS-1:0]            req,
    input  logic [NUM_CLIENTS-1:0]            we,
    input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] addr,
    input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] wdata,
    output logic [NUM_CLIENTS-1:0]            gnt,
    output logic [NUM_CLIENTS-1:0]            rvalid,
    output logic [DATA_WIDTH-1:0]             rdata,
    output logic [ADDR_WIDTH-1:0]             sram_wr_addr,
    output logic [ADDR_WIDTH-1:0]             sram_rd_addr,
    output logic                              sram_write_en,
    output logic [DATA_WIDTH-1:0]             sram_wr_data,
    input  logic [DATA_WIDTH-1:0]             sram_rd_data
);

    localparam int PTR_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

    logic [NUM_CLIENTS-1:0] rd_cand;
    logic [NUM_CLIENTS-1:0] wr_cand;
    logic [NUM_CLIENTS-1:0] rd_onehot;
    logic [NUM_CLIENTS-1:0] wr_onehot;
    logic [NUM_CLIENTS-1:0] rd_tag;
    logic [PTR_W-1:0]       rd_ptr;
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_idx;
    logic [PTR_W-1:0]       wr_idx;
    logic                   rd_found;
    logic                   wr_found;
    logic                   rd_grant;
    logic                   wr_grant;
    logic [ADDR_WIDTH-1:0]  rd_addr_q;

    assign rd_cand = req & ~we;
    assign wr_cand = req & we;

    // Scan candidates from each side's pointer upward, wrapping; first hit wins.
    always_comb begin
        rd_found = 1'b0;
        rd_idx   = '0;
        wr_found = 1'b0;
        wr_idx   = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (!rd_found && rd_cand[(int'(rd_ptr) + i) % NUM_CLIENTS]) begin
                rd_found = 1'b1;
                rd_idx   = PTR_W'((int'(rd_ptr) + i) % NUM_CLIENTS);
            end
            if (!wr_found && wr_cand[(int'(wr_ptr) + i) % NUM_CLIENTS]) begin
                wr_found = 1'b1;
                wr_idx   = PTR_W'((int'(wr_ptr) + i) % NUM_CLIENTS);
            end
        end
    end

    // Nothing is granted while reset is held.
    assign rd_grant  = rd_found & ~rst;
    assign wr_grant  = wr_found & ~rst;
    assign rd_onehot = rd_grant ? (NUM_CLIENTS'(1) << rd_idx) : '0;
    assign wr_onehot = wr_grant ? (NUM_CLIENTS'(1) << wr_idx) : '0;
    assign gnt       = rd_onehot | wr_onehot;

    // Drive the SRAM ports from the winners; the read address holds when idle.
    always_comb begin
        sram_write_en = wr_grant;
        sram_wr_addr  = '0;
        sram_wr_data  = '0;
        sram_rd_addr  = rd_addr_q;
        if (wr_grant) begin
            sram_wr_addr = addr[int'(wr_idx)*ADDR_WIDTH +: ADDR_WIDTH];
            sram_wr_data = wdata[int'(wr_idx)*DATA_WIDTH +: DATA_WIDTH];
        end
        if (rd_grant) begin
            sram_rd_addr = addr[int'(rd_idx)*ADDR_WIDTH +: ADDR_WIDTH];
        end
    end

    assign rvalid = rd_tag;
    assign rdata  = sram_rd_data;

    // Advance pointers past each winner, remember the read address, tag the read.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            rd_tag    <= '0;
            rd_addr_q <= '0;
        end else begin
            if (rd_grant) begin
                rd_ptr    <= PTR_W'((int'(rd_idx) + 1) % NUM_CLIENTS);
                rd_addr_q <= sram_rd_addr;
            end
            if (wr_grant) begin
                wr_ptr <= PTR_W'((int'(wr_idx) + 1) % NUM_CLIENTS);
            end
            rd_tag <= rd_onehot;
        end
    end

endmodule
